// File: rtl/router_port.sv
// router_port: node-facing port of the 4x4 mesh router. It turns serial ingress bytes into a packet queue and serializes egress packets.
// Define ROUTER_PORT_STATS_EN to add the saturating stat_rx/stat_tx/stat_drop counters (and the CNTW parameter).
module router_port #(
    parameter int DEPTH = 4
`ifdef ROUTER_PORT_STATS_EN
    ,
    parameter int CNTW  = 16
`endif
) (
    input  logic        clk,
    input  logic        rst_b,
    output logic        free_outbound,
    input  logic        put_outbound,
    input  logic [7:0]  payload_outbound,
    input  logic        free_inbound,
    output logic        put_inbound,
    output logic [7:0]  payload_inbound,
    output logic        ing_valid,
    output logic [31:0] ing_pkt,
    output logic [3:0]  ing_dest,
    input  logic        ing_grant,
    input  logic        egr_valid,
    input  logic [31:0] egr_pkt,
    output logic        egr_ready,
    output logic        err_frame,
    output logic        err_overflow
`ifdef ROUTER_PORT_STATS_EN
    ,
    output logic [CNTW-1:0] stat_rx,
    output logic [CNTW-1:0] stat_tx,
    output logic [CNTW-1:0] stat_drop
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
    localparam logic [AW+1:0] LIMIT = (AW+2)'(DEPTH);

    typedef enum logic [1:0] {I_IDLE, I_B1, I_B2, I_B3} ing_state_t;
    typedef enum logic [2:0] {E_IDLE, E_WAIT, E_B0, E_B1, E_B2, E_B3} egr_state_t;

    ing_state_t      r_ist, w_ist_nxt;
    logic            r_drop;
    logic [23:0]     r_asm;
    logic            r_err_frame, r_err_overflow;
    logic            w_wr, w_pop, w_frame_err, w_ovf_err, w_inflight;
    logic [AW+1:0]   w_occ;
    logic [31:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [AW:0]     r_count;

    egr_state_t      r_est, w_est_nxt;
    logic [31:0]     r_epkt;
    logic            r_put_in, w_put_nxt, r_egr_ready, w_accept;
    logic [7:0]      r_pay_in, w_pay_nxt;

    // A packet whose first byte arrived while the queue was full is not counted as in flight.
    assign w_inflight    = (r_ist != I_IDLE) && !r_drop;
    assign w_occ         = {1'b0, r_count} + {{(AW+1){1'b0}}, w_inflight};
    assign free_outbound = (w_occ < LIMIT);
    assign w_pop         = ing_grant && (r_count != {(AW+1){1'b0}});
    assign ing_valid     = (r_count != {(AW+1){1'b0}});
    assign ing_pkt       = r_mem[r_rptr];
    assign ing_dest      = r_mem[r_rptr][27:24];
    assign err_frame     = r_err_frame;
    assign err_overflow  = r_err_overflow;

    // Ingress next state, queue write strobe and error detection.
    always_comb begin
        w_ist_nxt   = r_ist;
        w_wr        = 1'b0;
        w_frame_err = 1'b0;
        w_ovf_err   = 1'b0;
        case (r_ist)
            I_IDLE: begin
                if (put_outbound) w_ist_nxt = I_B1;
                else              w_ist_nxt = I_IDLE;
            end
            I_B1, I_B2: begin
                if (put_outbound) begin
                    w_ist_nxt = (r_ist == I_B1) ? I_B2 : I_B3;
                end else begin
                    w_ist_nxt   = I_IDLE;
                    w_frame_err = 1'b1;
                end
            end
            I_B3: begin
                w_ist_nxt = I_IDLE;
                if (put_outbound) begin
                    w_wr      = !r_drop;
                    w_ovf_err = r_drop;
                end else begin
                    w_frame_err = 1'b1;
                end
            end
            default: w_ist_nxt = I_IDLE;
        endcase
    end

    // Ingress state, drop decision (taken at the first byte) and byte assembly.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_ist          <= I_IDLE;
            r_drop         <= 1'b0;
            r_asm          <= 24'd0;
            r_err_frame    <= 1'b0;
            r_err_overflow <= 1'b0;
        end else begin
            r_ist          <= w_ist_nxt;
            r_err_frame    <= w_frame_err;
            r_err_overflow <= w_ovf_err;
            if (r_ist == I_IDLE && put_outbound) r_drop <= (r_count == FULL);
            if (put_outbound && r_ist != I_B3)   r_asm  <= {r_asm[15:0], payload_outbound};
        end
    end

    // Circular packet queue; a simultaneous write and pop leaves the occupancy unchanged.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_count <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 32'd0;
        end else begin
            if (w_wr) begin
                r_mem[r_wptr] <= {r_asm, payload_outbound};
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_accept        = egr_valid && r_egr_ready;
    assign egr_ready       = r_egr_ready;
    assign put_inbound     = r_put_in;
    assign payload_inbound = r_pay_in;

    // Egress next state; byte outputs are computed for the next state so they can be registered.
    always_comb begin
        w_est_nxt = r_est;
        w_put_nxt = 1'b0;
        w_pay_nxt = 8'd0;
        case (r_est)
            E_IDLE: begin
                if (egr_valid) w_est_nxt = E_WAIT;
                else           w_est_nxt = E_IDLE;
            end
            E_WAIT: begin
                if (free_inbound) begin
                    w_est_nxt = E_B0;
                    w_put_nxt = 1'b1;
                    w_pay_nxt = r_epkt[31:24];
                end else begin
                    w_est_nxt = E_WAIT;
                end
            end
            E_B0: begin
                w_est_nxt = E_B1;
                w_pay_nxt = r_epkt[23:16];
            end
            E_B1: begin
                w_est_nxt = E_B2;
                w_pay_nxt = r_epkt[15:8];
            end
            E_B2: begin
                w_est_nxt = E_B3;
                w_pay_nxt = r_epkt[7:0];
            end
            E_B3:    w_est_nxt = E_IDLE;
            default: w_est_nxt = E_IDLE;
        endcase
    end

    // Egress state, held packet and registered node-side outputs.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_est       <= E_IDLE;
            r_epkt      <= 32'd0;
            r_put_in    <= 1'b0;
            r_pay_in    <= 8'd0;
            r_egr_ready <= 1'b1;
        end else begin
            r_est       <= w_est_nxt;
            r_put_in    <= w_put_nxt;
            r_pay_in    <= w_pay_nxt;
            r_egr_ready <= (w_est_nxt == E_IDLE);
            if (w_accept) r_epkt <= egr_pkt;
        end
    end

`ifdef ROUTER_PORT_STATS_EN
    logic [CNTW-1:0] r_stat_rx, r_stat_tx, r_stat_drop;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v, input logic en);
        return (en && (v != {CNTW{1'b1}})) ? v + CNTW'(1) : v;
    endfunction

    // Saturating packet statistics.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_stat_rx   <= {CNTW{1'b0}};
            r_stat_tx   <= {CNTW{1'b0}};
            r_stat_drop <= {CNTW{1'b0}};
        end else begin
            r_stat_rx   <= sat_inc(r_stat_rx, w_wr);
            r_stat_tx   <= sat_inc(r_stat_tx, r_est == E_B3);
            r_stat_drop <= sat_inc(r_stat_drop, r_err_frame || r_err_overflow);
        end
    end

    assign stat_rx   = r_stat_rx;
    assign stat_tx   = r_stat_tx;
    assign stat_drop = r_stat_drop;
`endif

endmodule

// File: doc/router_port.md
Name: router_port

Overview:
One node-facing port of the 4x4 mesh router. It sits directly downstream of a node's outbound serializer and directly upstream of the node's inbound deserializer.
- Ingress: assembles 4-byte serial packets into 32-bit words, queues them, and presents the head packet and its destID to the switch.
- Egress: takes 32-bit packets from the switch and serializes them to the node, MSB byte first, using the free/put handshake.
- Packet format: {sourceID[31:28], destID[27:24], data[23:0]}.

Parameters:
DEPTH, 4, ingress queue depth in packets (power of 2, >=2)
CNTW, 16, statistics counter width (used only with ROUTER_PORT_STATS_EN)

Ports:
clk  in  1  clock, rising-edge
rst_b  in  1  reset, asynchronous, active-low
free_outbound  out  1  to node: port can accept one full packet starting next cycle
put_outbound  in  1  from node: byte valid, high for 4 consecutive cycles per packet
payload_outbound  in  8  from node: packet byte, [31:24] first
free_inbound  in  1  from node: node ready to receive a packet
put_inbound  out  1  to node: high for the first byte only
payload_inbound  out  8  to node: packet byte
ing_valid  out  1  head of ingress queue valid
ing_pkt  out  32  head packet (show-ahead)
ing_dest  out  4  ing_pkt[27:24]
ing_grant  in  1  switch pops head this cycle
egr_valid  in  1  switch offers packet
egr_pkt  in  32  offered packet
egr_ready  out  1  port accepts egr_pkt this cycle
err_frame  out  1  one-cycle pulse: put_outbound dropped mid-packet
err_overflow  out  1  one-cycle pulse: packet dropped because queue full

Behaviour:
- Reset (async): ingress FSM to I_IDLE, egress FSM to E_IDLE, queue empty, partial packets discarded.
  - Reset values: free_outbound=1, put_inbound=0, payload_inbound=0, egr_ready=1, ing_valid=0, ing_pkt=0, err_*=0.
- Ingress FSM, states I_IDLE, I_B1, I_B2, I_B3:
  - I_IDLE with put_outbound=1: capture byte into [31:24], go to I_B1. Record drop=1 if occupancy==DEPTH.
  - I_B1 captures [23:16], I_B2 captures [15:8], I_B3 captures [7:0].
  - At the I_B3 edge, write the packet to the queue unless drop=1. If drop=1, pulse err_overflow next cycle.
  - I_B3 always returns to I_IDLE. A new packet may start in the very next cycle.
  - put_outbound=0 in I_B1..I_B3: discard the partial packet, go to I_IDLE, pulse err_frame next cycle.
- free_outbound = (occupancy + inflight) < DEPTH.
  - inflight=1 in states I_B1..I_B3 when drop=0.
  - Decoded from registers only; no combinational path from put_outbound or ing_grant.
  - The node samples it at its last byte, so a back-to-back packet must already be accounted for.
- Queue: circular buffer with read/write pointers and an occupancy counter (0..DEPTH).
  - ing_valid = occupancy!=0; ing_pkt = entry at the read pointer.
  - ing_grant with the queue empty is ignored.
  - A write and a pop in the same cycle both take effect; occupancy is unchanged.
  - Latency: last byte in cycle T gives ing_valid=1 in cycle T+1 (queue previously empty).
- Egress FSM, states E_IDLE, E_WAIT, E_B0, E_B1, E_B2, E_B3:
  - egr_ready=1 only in E_IDLE. egr_valid&egr_ready latches egr_pkt and goes to E_WAIT.
  - E_WAIT: advance to E_B0 when free_inbound=1, otherwise hold.
  - E_B0: put_inbound=1, payload_inbound=[31:24]. E_B1 drives [23:16], E_B2 drives [15:8], E_B3 drives [7:0]. put_inbound=0 in E_B1..E_B3.
  - E_B3 returns to E_IDLE.
  - put_inbound and payload_inbound are registered; payload_inbound=0 outside E_B0..E_B3.
  - Minimum latency: accept at edge E gives first byte in cycle E+2.
  - free_inbound is ignored during E_B0..E_B3.
- Ingress and egress paths are fully independent.

Optional Feature:
ROUTER_PORT_STATS_EN
- Defined: adds output ports stat_rx[CNTW], stat_tx[CNTW], stat_drop[CNTW].
  - stat_rx increments per packet written to the queue.
  - stat_tx increments per completed E_B3.
  - stat_drop increments per err_frame or err_overflow pulse.
  - Counters saturate at all-ones and reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single packet: bytes 0x12,0x34,0x56,0x78 with put_outbound high 4 cycles -> ing_valid next cycle, ing_pkt=0x12345678, ing_dest=0x2; ing_grant -> ing_valid=0.
- Fill: 4 back-to-back packets, no grant -> free_outbound drops during the 4th packet's bytes and stays 0; a 5th packet forced anyway -> err_overflow pulse, queue contents unchanged, stat_drop=1 (stats build).
- Framing: put_outbound high 2 cycles then low -> err_frame pulse, ing_valid stays 0, next good packet 0xA1B2C3D4 captured correctly.
- Egress: egr_pkt=0xCAFEF00D, free_inbound=0 for 3 cycles then 1 -> put_inbound single pulse with 0xCA, then 0xFE, 0xF0, 0x0D on consecutive cycles; egr_ready low until after the last byte.
- Simultaneous: queue at occupancy 3, write completes in the same cycle as ing_grant -> occupancy stays 3, FIFO order preserved.
- Reset mid-operation: assert rst_b low during ingress I_B2 and egress E_B1 -> all outputs at reset values; after release, fresh packets on both paths succeed.
